// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC multiplexed-bus sequencer: FSM state codes,
// access sub-phase codes, default RTC addresses and the RAM index width helper.
package rtc_bus_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_ADDR_SU = 4'd2;
  localparam logic [3:0] S_ADDR_PW = 4'd3;
  localparam logic [3:0] S_ADDR_HD = 4'd4;
  localparam logic [3:0] S_DATA_SU = 4'd5;
  localparam logic [3:0] S_DATA_PW = 4'd6;
  localparam logic [3:0] S_DATA_HD = 4'd7;
  localparam logic [3:0] S_STORE   = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [1:0] PH_SU = 2'd0;
  localparam logic [1:0] PH_PW = 2'd1;
  localparam logic [1:0] PH_HD = 2'd2;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h21;
  localparam logic [7:0] DEF_CMD_ADDR  = 8'hF0;
  localparam logic [7:0] DEF_CMD_RD    = 8'hF0;

  // RAM slot index must reach N_REGS (slot 0 is the command slot).
  function automatic int idx_w(input int n_regs);
    return (n_regs < 1) ? 1 : $clog2(n_regs + 1);
  endfunction

endpackage

// File: rtl/rtc_bus_access.sv
// Timing engine for one RTC bus access: counts T_PHASE cycles per sub-phase
// and decodes the active-low strobes, a_d and output enable.
module rtc_bus_access
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       is_addr,
  input  logic       is_read,
  input  logic [1:0] phase,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       a_d,
  output logic       oe,
  output logic       last
);

  localparam int CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

  logic [CNT_W-1:0] cnt;
  logic             pulse;

  assign last = go && (cnt == CNT_W'(T_PHASE - 1));

  // Sub-phase changes only happen on last, so this also clears on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (!go || last)  cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

  assign pulse = go && (phase == PH_PW);
  assign cs    = !pulse;
  // Address accesses are always writes of the address; only data accesses may read.
  assign wr    = !(pulse && (is_addr || !is_read));
  assign rd    = !(pulse && !is_addr && is_read);
  assign a_d   = !(go && is_addr);
  assign oe    = go && (is_addr || !is_read);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Block read/write sequencer between the controller, the RTC multiplexed bus
// and the local time RAM (slot 0 = command, slot i+1 = data register i).
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int                 N_REGS    = 6,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  BASE_ADDR = DATA_W'(DEF_BASE_ADDR),
  parameter logic [DATA_W-1:0]  CMD_ADDR  = DATA_W'(DEF_CMD_ADDR),
  parameter logic [DATA_W-1:0]  CMD_RD    = DATA_W'(DEF_CMD_RD),
  parameter int                 T_PHASE   = 4,
  localparam int                IDX_W     = idx_w(N_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a start pulse is accepted only while busy=0; busy rises the next
  // cycle and stays high through the one-cycle done pulse, falling with it.
  input  logic              start_wr,
  input  logic              start_rd,
  output logic              busy,
  output logic              done,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in,
  output logic [IDX_W-1:0]  ram_idx,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        state_dbg
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_REGS);

  logic [3:0]        state;
  logic [IDX_W-1:0]  k;
  logic              is_rd;
  logic              fetch_2nd;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cap_q;

  logic              acc_go;
  logic              acc_is_addr;
  logic              acc_is_read;
  logic [1:0]        acc_phase;
  logic              acc_last;
  logic              acc_a_d;

  always_comb begin
    acc_go      = 1'b0;
    acc_is_addr = 1'b0;
    acc_phase   = PH_SU;
    case (state)
      S_ADDR_SU: begin acc_go = 1'b1; acc_is_addr = 1'b1; acc_phase = PH_SU; end
      S_ADDR_PW: begin acc_go = 1'b1; acc_is_addr = 1'b1; acc_phase = PH_PW; end
      S_ADDR_HD: begin acc_go = 1'b1; acc_is_addr = 1'b1; acc_phase = PH_HD; end
      S_DATA_SU: begin acc_go = 1'b1; acc_phase = PH_SU; end
      S_DATA_PW: begin acc_go = 1'b1; acc_phase = PH_PW; end
      S_DATA_HD: begin acc_go = 1'b1; acc_phase = PH_HD; end
      default: ;
    endcase
  end

  // The command access of a read block is itself a write of CMD_RD.
  assign acc_is_read = is_rd && (k != '0);

  rtc_bus_access #(
    .T_PHASE (T_PHASE)
  ) u_access (
    .clk     (clk),
    .reset   (reset),
    .go      (acc_go),
    .is_addr (acc_is_addr),
    .is_read (acc_is_read),
    .phase   (acc_phase),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .a_d     (acc_a_d),
    .oe      (ad_oe),
    .last    (acc_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      is_rd     <= 1'b0;
      fetch_2nd <= 1'b0;
      wdata_q   <= '0;
      cap_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_wr) begin
            is_rd     <= 1'b0;
            k         <= '0;
            fetch_2nd <= 1'b0;
            state     <= S_FETCH;
          end else if (start_rd) begin
            is_rd <= 1'b1;
            k     <= '0;
            state <= S_ADDR_SU;
          end
        end
        S_FETCH: begin
          if (!fetch_2nd) begin
            fetch_2nd <= 1'b1;
          end else begin
            fetch_2nd <= 1'b0;
            wdata_q   <= ram_rdata;
            state     <= S_ADDR_SU;
          end
        end
        S_ADDR_SU: if (acc_last) state <= S_ADDR_PW;
        S_ADDR_PW: if (acc_last) state <= S_ADDR_HD;
        S_ADDR_HD: if (acc_last) state <= S_DATA_SU;
        S_DATA_SU: if (acc_last) state <= S_DATA_PW;
        S_DATA_PW: begin
          if (acc_last) begin
            if (acc_is_read) cap_q <= ad_in;
            state <= S_DATA_HD;
          end
        end
        S_DATA_HD: begin
          if (acc_last) begin
            if (!is_rd) begin
              if (k == K_LAST) begin
                state <= S_DONE;
              end else begin
                k     <= k + IDX_W'(1);
                state <= S_FETCH;
              end
            end else if (k == '0) begin
              k     <= IDX_W'(1);
              state <= S_ADDR_SU;
            end else begin
              state <= S_STORE;
            end
          end
        end
        S_STORE: begin
          if (k == K_LAST) begin
            state <= S_DONE;
          end else begin
            k     <= k + IDX_W'(1);
            state <= S_ADDR_SU;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus value is decoded from registered state, so it holds across SU..HD.
  always_comb begin
    ad_out = '0;
    if (acc_go) begin
      if (acc_is_addr)
        ad_out = (k == '0) ? CMD_ADDR : BASE_ADDR + DATA_W'(k - IDX_W'(1));
      else if (!is_rd)
        ad_out = wdata_q;
      else if (k == '0)
        ad_out = CMD_RD;
    end
  end

  assign a_d       = acc_a_d;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign ram_rd_en = (state == S_FETCH) && !fetch_2nd;
  assign ram_wr_en = (state == S_STORE);
  assign ram_idx   = ((state == S_FETCH) || (state == S_STORE)) ? k : '0;
  assign ram_wdata = (state == S_STORE) ? cap_q : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: default instance for write/read/
// priority/reset scenarios, and a short N_REGS=2, T_PHASE=1 instance.
module tb_rtc_bus_sequencer;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic       start_wr = 1'b0, start_rd = 1'b0;
  logic       busy, done, a_d, cs, rd, wr, ad_oe, ram_rd_en, ram_wr_en;
  logic [7:0] ad_out, ad_in, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [2:0] ram_idx;
  logic [3:0] state_dbg;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .busy(busy), .done(done), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ram_idx(ram_idx),
    .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata), .ram_wr_en(ram_wr_en),
    .ram_wdata(ram_wdata), .state_dbg(state_dbg)
  );

  // ---------------- small instance ----------------
  logic       start_wr1 = 1'b0;
  logic       start_rd1 = 1'b0;
  logic       busy1, done1, a_d1, cs1, rd1, wr1, ad_oe1, ram_rd_en1, ram_wr_en1;
  logic [7:0] ad_out1, ram_wdata1;
  logic [7:0] ad_in1 = 8'h00;
  logic [7:0] ram_rdata1 = 8'h00;
  logic [1:0] ram_idx1;
  logic [3:0] state_dbg1;

  rtc_bus_sequencer #(.N_REGS(2), .T_PHASE(1), .BASE_ADDR(8'h30)) dut1 (
    .clk(clk), .reset(reset), .start_wr(start_wr1), .start_rd(start_rd1),
    .busy(busy1), .done(done1), .a_d(a_d1), .cs(cs1), .rd(rd1), .wr(wr1),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1), .ram_idx(ram_idx1),
    .ram_rd_en(ram_rd_en1), .ram_rdata(ram_rdata1), .ram_wr_en(ram_wr_en1),
    .ram_wdata(ram_wdata1), .state_dbg(state_dbg1)
  );

  // ---------------- RAM and RTC models ----------------
  logic [7:0] ram0 [0:6];
  logic [7:0] ram1 [0:2];
  logic [7:0] rtc_addr = 8'h00;

  always @(posedge clk) begin
    if (ram_rd_en)  ram_rdata  <= ram0[ram_idx];
    if (ram_rd_en1) ram_rdata1 <= ram1[ram_idx1];
  end

  always_comb ad_in = (rtc_addr >= 8'h21 && rtc_addr <= 8'h26) ? 8'h45 : 8'h00;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] ram_q[$];
  logic [7:0]  addr1_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         wr_w = 0, busy_cnt = 0, rd_cnt = 0, oe_viol = 0, slot4_wr = 0, busy_cnt1 = 0;
  logic       pulse_data = 1'b0;
  logic [7:0] pulse_val  = 8'h00;
  logic [15:0] got16;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!rd) begin
      rd_cnt++;
      if (ad_oe) oe_viol++;
    end
    if (!wr) begin
      wr_w++;
      pulse_data = a_d;
      pulse_val  = ad_out;
      if (!a_d) rtc_addr = ad_out;
    end else if (wr_w != 0) begin
      check_eq("wr_width", wr_w, 4);
      wr_w = 0;
      if (pulse_data) begin
        check_eq("bus_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          got16 = {rtc_addr, pulse_val};
          check_eq("bus_txn", got16, exp_q.pop_front());
        end
      end
    end
    if (ram_wr_en) begin
      if (ram_idx == 3'd4) slot4_wr++;
      check_eq("ram_q_nonempty", ram_q.size() > 0, 1);
      if (ram_q.size() > 0) check_eq("ram_write", {5'b0, ram_idx, ram_wdata}, ram_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (busy1) busy_cnt1++;
    if (!wr1 && !a_d1) begin
      check_eq("n2_addr_q_nonempty", addr1_q.size() > 0, 1);
      if (addr1_q.size() > 0) check_eq("n2_addr", ad_out1, addr1_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic s_wr, input logic s_rd);
    @(negedge clk);
    start_wr = s_wr;
    start_rd = s_rd;
    @(negedge clk);
    start_wr = 1'b0;
    start_rd = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, done, 1);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
  endtask

  task automatic push_write_block();
    for (int k = 0; k <= 6; k++)
      exp_q.push_back({(k == 0) ? 8'hF0 : 8'(8'h21 + k - 1), ram0[k]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 reset = 1'b1;
    ram0[0] = 8'h10; ram0[1] = 8'h59; ram0[2] = 8'h30; ram0[3] = 8'h12;
    ram0[4] = 8'h25; ram0[5] = 8'h12; ram0[6] = 8'h16;
    for (int i = 0; i < 3; i++) ram1[i] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {cs, rd, wr, a_d, ad_oe, busy, done, ram_rd_en, ram_wr_en}, 9'b111100000);
    check_eq("reset_data", {ad_out, ram_idx, ram_wdata}, 19'h0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_ctrl", {cs, rd, wr, a_d, ad_oe, busy, done}, 7'b1111000);

    // Write block with the reference RAM image.
    push_write_block();
    busy_cnt = 0;
    pulse_start(1'b1, 1'b0);
    wait_done(400, "wr");
    check_eq("wr_busy_cycles", busy_cnt, 183);
    check_eq("wr_bus_q_empty", exp_q.size(), 0);

    // Read block: command write first, then six RAM stores of 0x45.
    exp_q.push_back(16'hF0F0);
    for (int k = 1; k <= 6; k++) ram_q.push_back({8'(k), 8'h45});
    busy_cnt = 0; rd_cnt = 0; oe_viol = 0;
    pulse_start(1'b0, 1'b1);
    wait_done(400, "rd");
    check_eq("rd_busy_cycles", busy_cnt, 175);
    check_eq("rd_oe_during_pw", oe_viol, 0);
    check_eq("rd_strobe_cycles", rd_cnt, 24);
    check_eq("rd_bus_q_empty", exp_q.size(), 0);
    check_eq("rd_ram_q_empty", ram_q.size(), 0);

    // Simultaneous starts pick write; mid-transfer starts are ignored.
    for (int i = 0; i <= 6; i++) ram0[i] = 8'($urandom_range(0, 255));
    push_write_block();
    busy_cnt = 0;
    pulse_start(1'b1, 1'b1);
    repeat (40) @(negedge clk);
    pulse_start(1'b1, 1'b1);
    repeat (30) @(negedge clk);
    pulse_start(1'b0, 1'b1);
    wait_done(400, "prio");
    repeat (20) @(negedge clk);
    check_eq("prio_busy_cycles", busy_cnt, 183);
    check_eq("prio_idle_after", busy, 0);
    check_eq("prio_bus_q_empty", exp_q.size(), 0);

    // Reset during DATA_PW of data register 3 (RTC address 0x24) in a read.
    exp_q.push_back(16'hF0F0);
    for (int k = 1; k <= 3; k++) ram_q.push_back({8'(k), 8'h45});
    slot4_wr = 0;
    pulse_start(1'b0, 1'b1);
    begin
      int n = 0;
      while (!(!rd && rtc_addr == 8'h24) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check_eq("rst_reached_reg3_pw", {rd, rtc_addr}, 9'h024);
    end
    #1 reset = 1'b1;
    #1;
    check_eq("rst_async_strobes", {cs, rd, wr, a_d, ad_oe}, 5'b11110);
    check_eq("rst_async_busy", {busy, ram_wr_en, state_dbg}, 6'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (250) @(negedge clk);
    check_eq("rst_no_slot4_write", slot4_wr, 0);
    check_eq("rst_ram_q_empty", ram_q.size(), 0);
    check_eq("rst_bus_q_empty", exp_q.size(), 0);
    check_eq("rst_stays_idle", busy, 0);

    // Small instance: N_REGS=2, T_PHASE=1, BASE_ADDR=0x30.
    addr1_q.push_back(8'hF0);
    addr1_q.push_back(8'h30);
    addr1_q.push_back(8'h31);
    busy_cnt1 = 0;
    @(negedge clk);
    start_wr1 = 1'b1;
    @(negedge clk);
    start_wr1 = 1'b0;
    begin
      int n = 0;
      while (!done1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_eq("n2_done_seen", done1, 1);
    end
    @(negedge clk);
    check_eq("n2_busy_cycles", busy_cnt1, 25);
    check_eq("n2_addr_q_empty", addr1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised sequencer for the RTC's multiplexed address/data bus. It reads or writes a block of N_REGS time registers, each preceded by a command-register access, and moves data to or from the local time RAM. It replaces the fixed write-only RTC FSM with a single engine that supports both directions and configurable register count, base address and strobe timing. It sits between the top-level controller (start/busy/done) and the RTC pins plus the time RAM.

## Interface
- N_REGS, 6: number of data registers transferred after the command access (1..15)
- DATA_W, 8: bus and RAM data width
- BASE_ADDR, 8'h21: RTC address of data register 0; register i uses BASE_ADDR+i
- CMD_ADDR, 8'hF0: RTC command/status register address
- CMD_RD, 8'hF0: command value written before a read block
- T_PHASE, 4: cycles per setup, pulse and hold sub-phase (>=1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start_wr  in  1  one-cycle request: RAM -> RTC block write
- start_rd  in  1  one-cycle request: RTC -> RAM block read
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- a_d  out  1  0 = address phase, 1 = data phase
- cs, rd, wr  out  1 each  active-low RTC strobes
- ad_out  out  DATA_W  bus drive value
- ad_oe  out  1  bus output enable (1 = drive)
- ad_in  in  DATA_W  bus sampled value
- ram_idx  out  $clog2(N_REGS+1)  RAM slot (0 = command, i+1 = data register i)
- ram_rd_en  out  1  RAM read strobe (1-cycle read latency)
- ram_rdata  in  DATA_W  RAM read data
- ram_wr_en  out  1  RAM write strobe
- ram_wdata  out  DATA_W  RAM write data

## Operation
- States: IDLE, FETCH, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, STORE, DONE.
- IDLE: start_wr takes priority if it is asserted together with start_rd. Starts while busy are ignored.
- Write block: for slot k = 0..N_REGS, run FETCH, then an address access and a data access.
  - FETCH lasts 2 cycles. Cycle 1 asserts ram_rd_en with ram_idx=k. Cycle 2 latches ram_rdata.
  - Address is CMD_ADDR for k=0, else BASE_ADDR+k-1. The data access drives the latched value with wr low.
- Read block: the command access writes CMD_RD to CMD_ADDR with no FETCH. Then, for each data register i, run an address access, then a data access with rd low and ad_oe=0.
  - ad_in is captured on the last DATA_PW cycle.
  - STORE (1 cycle) asserts ram_wr_en with ram_idx=i+1 and ram_wdata=captured value.
- Each access is SU, PW, HD, each lasting T_PHASE cycles. cs and wr/rd are low only during PW. ad_out and ad_oe are stable across SU..HD. a_d=0 for ADDR_*, 1 for DATA_*.
- DONE: 1 cycle, done=1, then return to IDLE.
- Reset mid-transfer: all outputs return to reset values immediately, no RAM write completes, state goes to IDLE.

## Timing
- Reset and IDLE values: cs=rd=wr=1, a_d=1, ad_oe=0, ad_out=0, busy=0, done=0, ram_rd_en=ram_wr_en=0, ram_idx=0, ram_wdata=0.
- busy rises the cycle after the start is sampled. It stays high through the DONE cycle and falls together with done.
- Cycles with busy=1: write = (N_REGS+1)*(2+6*T_PHASE)+1; read = 6*T_PHASE + N_REGS*(6*T_PHASE+1) + 1.
- The phase counter wraps at T_PHASE-1 and is cleared on every state change.
- ram_idx arithmetic: k ranges 0..N_REGS with no wrap. RTC address arithmetic is DATA_W-bit modulo.

## Structure
- Shared package rtc_bus_pkg holds the state enum, default BASE_ADDR/CMD_ADDR/CMD_RD and the IDX_W helper.
- Sub-module rtc_bus_access implements the SU/PW/HD timing engine for a single access, with inputs go, is_addr and is_read, and outputs cs/rd/wr/a_d/oe and last. The sequencer instantiates it once.

## Test plan
- Write block, defaults, RAM = {0x10, 0x59, 0x30, 0x12, 0x25, 0x12, 0x16}:
  - Bus shows (F0,10), (21,59) … (26,16) with wr pulses exactly 4 cycles wide.
  - done arrives after 183 busy cycles.
- Read block, RTC model returns 0x45 at 0x21..0x26:
  - The command write of 0xF0 comes first.
  - RAM slots 1..6 are written with 0x45.
  - ad_oe=0 during every DATA_PW. busy count is 175.
- start_wr and start_rd asserted together: a write block runs. Starts pulsed mid-transfer produce no second block.
- Reset asserted during DATA_PW of register 3 in a read: cs/rd rise asynchronously, no ram_wr_en occurs for slot 4, and busy=0.
- N_REGS=2, T_PHASE=1, BASE_ADDR=0x30: addresses F0, 30, 31 are written; the write busy count is 25.
